// File: rtl/uart_pkg.sv
// Shared state encodings and timing helpers for the uart_responder block.
package uart_pkg;

  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  localparam int RX_FIFO_DEPTH = 4;

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int calc_half_div(input int clk_freq, input int baud);
    return (clk_freq / baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for received bytes; head is visible combinationally,
// a push while full is dropped unless a pop frees the slot in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_push_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_head,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/uart_responder.sv
// 8N1 UART target for the CPU's memory-mapped UART strobes.
// Define UART_RX_FIFO_EN to replace the single-byte RX buffer with a 4-entry FIFO.
module uart_responder
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rdn,
  input  logic       uart_wrn,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       uart_dataready,
  output logic       uart_tbre,
  output logic       uart_tsre,
  input  logic       rxd,
  output logic       txd
);

  localparam int DIV  = calc_div(CLK_FREQ, BAUD);
  localparam int HALF = calc_half_div(CLK_FREQ, BAUD);
  localparam int CW   = $clog2(DIV);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  // Strobes are glitchy, so edges are taken only from the registered copies.
  logic       r_rdn;
  logic       r_rdn_d;
  logic       r_wrn;
  logic       r_wrn_d;
  logic [7:0] r_din;
  logic [7:0] r_wr_data;
  logic       w_wr_evt;
  logic       w_rd_evt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdn     <= 1'b1;
      r_rdn_d   <= 1'b1;
      r_wrn     <= 1'b1;
      r_wrn_d   <= 1'b1;
      r_din     <= 8'h00;
      r_wr_data <= 8'h00;
    end else begin
      r_rdn   <= uart_rdn;
      r_rdn_d <= r_rdn;
      r_wrn   <= uart_wrn;
      r_wrn_d <= r_wrn;
      r_din   <= data_in;
      if (!r_wrn) r_wr_data <= r_din;
    end
  end

  assign w_wr_evt = r_wrn & ~r_wrn_d;
  assign w_rd_evt = r_rdn & ~r_rdn_d;

  tx_state_t   r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_hold;
  logic [7:0]  r_tx_shift;
  logic        r_tbre;
  logic        r_tsre;
  logic        r_txd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= T_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= 3'd0;
      r_tx_hold  <= 8'h00;
      r_tx_shift <= 8'h00;
      r_tbre     <= 1'b1;
      r_tsre     <= 1'b1;
      r_txd      <= 1'b1;
    end else begin
      // A write only lands when the holding register is empty; otherwise it is dropped.
      if (w_wr_evt && r_tbre) begin
        r_tx_hold <= r_wr_data;
        r_tbre    <= 1'b0;
      end
      case (r_tx_state)
        T_IDLE: begin
          if (!r_tbre) begin
            r_tx_shift <= r_tx_hold;
            r_tbre     <= 1'b1;
            r_tsre     <= 1'b0;
            r_txd      <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_state <= T_START;
          end
        end
        T_START: begin
          if (r_tx_cnt == DIV_LAST) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= 3'd0;
            r_txd      <= r_tx_shift[0];
            r_tx_state <= T_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        T_DATA: begin
          if (r_tx_cnt == DIV_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
              r_txd      <= 1'b1;
              r_tx_state <= T_STOP;
            end else begin
              r_tx_bit   <= r_tx_bit + 1'b1;
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_txd      <= r_tx_shift[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        T_STOP: begin
          if (r_tx_cnt == DIV_LAST) begin
            r_tx_cnt   <= '0;
            r_tsre     <= r_tbre;
            r_tx_state <= T_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        default: r_tx_state <= T_IDLE;
      endcase
    end
  end

  logic        r_rx_s1;
  logic        r_rx_s2;
  logic        r_rx_prev;
  rx_state_t   r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic        r_rx_ferr;
  logic        r_rx_commit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1     <= 1'b1;
      r_rx_s2     <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_rx_state  <= R_IDLE;
      r_rx_cnt    <= '0;
      r_rx_bit    <= 3'd0;
      r_rx_shift  <= 8'h00;
      r_rx_ferr   <= 1'b0;
      r_rx_commit <= 1'b0;
    end else begin
      r_rx_s1     <= rxd;
      r_rx_s2     <= r_rx_s1;
      r_rx_prev   <= r_rx_s2;
      r_rx_commit <= 1'b0;
      case (r_rx_state)
        R_IDLE: begin
          if (r_rx_prev && !r_rx_s2) begin
            r_rx_cnt   <= '0;
            r_rx_state <= R_START;
          end
        end
        R_START: begin
          if (r_rx_cnt == HALF_LAST) begin
            r_rx_cnt <= '0;
            r_rx_bit <= 3'd0;
            r_rx_state <= r_rx_s2 ? R_IDLE : R_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (r_rx_cnt == DIV_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) r_rx_state <= R_STOP;
            else                  r_rx_bit   <= r_rx_bit + 1'b1;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        R_STOP: begin
          // After a framing error, park here until the line returns high.
          if (r_rx_ferr) begin
            if (r_rx_s2) begin
              r_rx_ferr  <= 1'b0;
              r_rx_state <= R_IDLE;
            end
          end else if (r_rx_cnt == DIV_LAST) begin
            r_rx_cnt <= '0;
            if (r_rx_s2) begin
              r_rx_commit <= 1'b1;
              r_rx_state  <= R_IDLE;
            end else begin
              r_rx_ferr <= 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: r_rx_state <= R_IDLE;
      endcase
    end
  end

  logic [7:0] w_head;

`ifdef UART_RX_FIFO_EN
  logic                                 w_full;
  logic                                 w_empty;
  logic [$clog2(RX_FIFO_DEPTH+1)-1:0]   w_count;

  uart_rx_fifo #(
    .DEPTH (RX_FIFO_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_rx_commit),
    .i_push_data (r_rx_shift),
    .i_pop       (w_rd_evt),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  assign uart_dataready = ~w_empty;
`else
  logic [7:0] r_rx_buf;
  logic       r_dataready;

  // A commit wins over a simultaneous read and silently overwrites an unread byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_buf    <= 8'h00;
      r_dataready <= 1'b0;
    end else if (r_rx_commit) begin
      r_rx_buf    <= r_rx_shift;
      r_dataready <= 1'b1;
    end else if (w_rd_evt) begin
      r_dataready <= 1'b0;
    end
  end

  assign w_head         = r_rx_buf;
  assign uart_dataready = r_dataready;
`endif

  logic [7:0] r_data_out;

  always_ff @(posedge clk) begin
    if (rst)            r_data_out <= 8'h00;
    else if (!uart_rdn) r_data_out <= w_head;
  end

  assign data_out  = r_data_out;
  assign data_oe   = ~r_rdn;
  assign uart_tbre = r_tbre;
  assign uart_tsre = r_tsre;
  assign txd       = r_txd;

endmodule

// File: tb/tb_uart_responder.sv
// Randomised scoreboard bench for uart_responder; monitors decode txd, tsre
// low periods and read cycles and compare them against queued expectations.
module tb_uart_responder;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rdn = 1'b1;
  logic       uart_wrn = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       rxd = 1'b1;
  logic [7:0] data_out;
  logic       data_oe;
  logic       uart_dataready;
  logic       uart_tbre;
  logic       uart_tsre;
  logic       txd;

  uart_responder #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .uart_rdn       (uart_rdn),
    .uart_wrn       (uart_wrn),
    .data_in        (data_in),
    .data_out       (data_out),
    .data_oe        (data_oe),
    .uart_dataready (uart_dataready),
    .uart_tbre      (uart_tbre),
    .uart_tsre      (uart_tsre),
    .rxd            (rxd),
    .txd            (txd)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         chk;
    logic [7:0] val;
  } rd_t;

  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  logic [7:0] tx_exp[$];
  int         tsre_exp[$];
  rd_t        rd_exp[$];
  logic [7:0] rx_model[$];

`ifdef UART_RX_FIFO_EN
  localparam int RX_CAP = 4;
`else
  localparam int RX_CAP = 1;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_write(input logic [7:0] b);
    @(negedge clk);
    data_in  = b;
    uart_wrn = 1'b0;
    cycles(2);
    uart_wrn = 1'b1;
    cycles(2);
    data_in = 8'($urandom);
  endtask

  task automatic tx_write(input logic [7:0] b, input bit accept, input bit exp_tbre);
    cpu_write(b);
    if (accept) tx_exp.push_back(b);
    cycles(3);
    check("tbre_after_wr", uart_tbre, exp_tbre);
  endtask

  task automatic tx_idle_check();
    check("tx_idle_txd", txd, 1);
    check("tx_idle_tbre", uart_tbre, 1);
    check("tx_idle_tsre", uart_tsre, 1);
  endtask

  // Reference buffer: keeps at most RX_CAP bytes; single-byte mode overwrites, FIFO mode drops.
  task automatic send_rx(input logic [7:0] b, input bit stop);
    @(negedge clk);
    rxd = 1'b0;
    cycles(DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      cycles(DIV);
    end
    rxd = stop;
    cycles(DIV);
    rxd = 1'b1;
    cycles(6);
    if (stop) begin
      if (RX_CAP == 1) begin
        rx_model.delete();
        rx_model.push_back(b);
      end else if (rx_model.size() < RX_CAP) begin
        rx_model.push_back(b);
      end
    end
    check("dataready_after_rx", uart_dataready, rx_model.size() != 0);
  endtask

  task automatic cpu_read();
    rd_t e;
    if (rx_model.size() > 0) begin
      e.chk = 1'b1;
      e.val = rx_model.pop_front();
    end else begin
      e.chk = 1'b0;
      e.val = 8'h00;
    end
    rd_exp.push_back(e);
    @(negedge clk);
    uart_rdn = 1'b0;
    cycles(3);
    uart_rdn = 1'b1;
    cycles(4);
    check("dataready_after_rd", uart_dataready, rx_model.size() != 0);
  endtask

  // TX frame decoder: samples mid-bit starting from the falling start edge.
  initial begin
    logic [7:0] b;
    logic [7:0] e;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (txd === 1'b0) begin
        cycles(DIV / 2 - 1);
        check("tx_start_bit", txd, 0);
        for (int i = 0; i < 8; i++) begin
          cycles(DIV);
          b[i] = txd;
        end
        cycles(DIV);
        check("tx_stop_bit", txd, 1);
        if (tx_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got frame %0h expected none", b);
        end else begin
          e = tx_exp.pop_front();
          check("tx_byte", b, e);
        end
      end
    end
  end

  initial begin
    int run;
    run = 0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (uart_tsre !== 1'b1) begin
        run++;
      end else if (run > 0) begin
        if (tsre_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tsre_unexpected: got low run %0d expected none", run);
        end else begin
          check("tsre_low_cycles", run, tsre_exp.pop_front());
        end
        run = 0;
      end
    end
  end

  initial begin
    logic prev_oe;
    rd_t  e;
    prev_oe = 1'b0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (data_oe === 1'b1 && prev_oe === 1'b0) begin
        if (rd_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: got read data %0h expected none", data_out);
        end else begin
          e = rd_exp.pop_front();
          if (e.chk) check("rd_data", data_out, e.val);
        end
      end
      prev_oe = data_oe;
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int n;
    cycles(3);
    check("rst_txd", txd, 1);
    check("rst_tbre", uart_tbre, 1);
    check("rst_tsre", uart_tsre, 1);
    check("rst_dataready", uart_dataready, 0);
    check("rst_data_oe", data_oe, 0);
    check("rst_data_out", data_out, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_txd", txd, 1);
      check("idle_tbre", uart_tbre, 1);
      check("idle_tsre", uart_tsre, 1);
      check("idle_dataready", uart_dataready, 0);
    end

    tsre_exp.push_back(160);
    tx_write(8'hA5, 1'b1, 1'b1);
    cycles(360);
    tx_idle_check();

    tsre_exp.push_back(321);
    tx_write(8'h31, 1'b1, 1'b1);
    cycles(15);
    tx_write(8'h32, 1'b1, 1'b0);
    cycles(15);
    tx_write(8'h77, 1'b0, 1'b0);
    cycles(400);
    tx_idle_check();

    // Bursts from idle: the first two bytes fit (shifter + holding), later ones are dropped.
    for (int r = 0; r < 6; r++) begin
      k = $urandom_range(1, 3);
      n = (k < 2) ? k : 2;
      tsre_exp.push_back(161 * n - 1);
      for (int j = 0; j < k; j++) begin
        tx_write(8'($urandom), j < 2, j == 0);
        if (j < k - 1) cycles($urandom_range(10, 40));
      end
      cycles(360);
      tx_idle_check();
    end

    send_rx(8'h5A, 1'b1);
    cpu_read();
    send_rx(8'h3C, 1'b0);
    send_rx(8'h11, 1'b1);
    cpu_read();
    cpu_read();

    @(negedge clk);
    rxd = 1'b0;
    cycles(3);
    rxd = 1'b1;
    cycles(30);
    check("glitch_dataready", uart_dataready, rx_model.size() != 0);

    for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1);
    for (int i = 0; i < 5; i++) cpu_read();

    for (int r = 0; r < 12; r++) begin
      send_rx(8'($urandom), $urandom_range(0, 4) != 0);
      if ($urandom_range(0, 1) == 1) cpu_read();
    end
    while (rx_model.size() > 0) cpu_read();
    cpu_read();

    cycles(20);
    check("tx_pending", tx_exp.size(), 0);
    check("tsre_pending", tsre_exp.size(), 0);
    check("rd_pending", rd_exp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
